// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, MemWr codes
// and the default legal data-memory window.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] RD    = 3'd0;
    localparam logic [2:0] WR_W  = 3'd1;
    localparam logic [2:0] WR_B  = 3'd2;
    localparam logic [2:0] WR_W2 = 3'd3;
    localparam logic [2:0] WR_H  = 3'd4;

    localparam logic [15:0] DM_BASE_DEF = 16'hff00;
    localparam logic [15:0] DM_TOP_DEF  = 16'hffff;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the data memory.
// Ports: pN_req/wr/ad/wdata/cut in, pN_gnt/rvalid/rdata/err out, plus the
// memory side Ad/WrData/MemWr/DMcut_sel and read data DM.
interface dm_arbiter_if;

    logic        p0_req;
    logic [2:0]  p0_wr;
    logic [15:0] p0_ad;
    logic [31:0] p0_wdata;
    logic [1:0]  p0_cut;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic [2:0]  p1_wr;
    logic [15:0] p1_ad;
    logic [31:0] p1_wdata;
    logic [1:0]  p1_cut;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic [15:0] Ad;
    logic [31:0] WrData;
    logic [2:0]  MemWr;
    logic [1:0]  DMcut_sel;
    logic [31:0] DM;

    modport slave (
        input  p0_req, p0_wr, p0_ad, p0_wdata, p0_cut,
        input  p1_req, p1_wr, p1_ad, p1_wdata, p1_cut,
        input  DM,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output Ad, WrData, MemWr, DMcut_sel
    );

    modport master (
        output p0_req, p0_wr, p0_ad, p0_wdata, p0_cut,
        output p1_req, p1_wr, p1_ad, p1_wdata, p1_cut,
        output DM,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  Ad, WrData, MemWr, DMcut_sel
    );

endinterface

// File: rtl/dm_arb_pick.sv
// Winner selection between two requesters.
// Ports: i_req0/i_req1 requests, i_pref port favoured on a tie, o_win winner ID.
module dm_arb_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_pref,
    output logic o_win
);

    // A lone request wins outright; only a tie consults the preference.
    assign o_win = (i_req0 & i_req1) ? i_pref : i_req1;

endmodule

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Ports: Clk, Reset (async, active low), bus (dm_arbiter_if.slave), busy.
// Macro DM_ARB_ROUND_ROBIN_EN: round-robin tie break; otherwise port 0 wins ties.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter logic [15:0] DM_BASE = DM_BASE_DEF,
    parameter logic [15:0] DM_TOP  = DM_TOP_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    dm_arbiter_if.slave bus,
    output logic        busy
);

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_wr;
    logic [15:0] r_ad;
    logic [31:0] r_wdata;
    logic [1:0]  r_cut;
    logic        r_win;
    logic        r_fault;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_any;
    logic        w_start;
    logic        w_win;
    logic        w_pref;
    logic [2:0]  w_sel_wr;
    logic [2:0]  w_wr;
    logic        w_lo;
    logic        w_hi;
    logic        w_fault;
    logic [31:0] w_rd;

    assign w_any   = bus.p0_req | bus.p1_req;
    assign w_start = (r_state == IDLE) && w_any;

`ifdef DM_ARB_ROUND_ROBIN_EN
    logic r_last;

    // Last winner; reset value 1 makes port 0 the first tie winner.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_last <= 1'b1;
        end else if (w_start) begin
            r_last <= w_win;
        end
    end

    assign w_pref = ~r_last;
`else
    assign w_pref = 1'b0;
`endif

    dm_arb_pick u_pick (
        .i_req0 (bus.p0_req),
        .i_req1 (bus.p1_req),
        .i_pref (w_pref),
        .o_win  (w_win)
    );

    // Undefined codes 5-7 degrade to a harmless read.
    assign w_sel_wr = w_win ? bus.p1_wr : bus.p0_wr;
    assign w_wr     = (w_sel_wr > WR_H) ? RD : w_sel_wr;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wr    <= RD;
            r_ad    <= DM_BASE;
            r_wdata <= '0;
            r_cut   <= '0;
            r_win   <= 1'b0;
        end else if (w_start) begin
            r_wr    <= w_wr;
            r_ad    <= w_win ? bus.p1_ad    : bus.p0_ad;
            r_wdata <= w_win ? bus.p1_wdata : bus.p0_wdata;
            r_cut   <= w_win ? bus.p1_cut   : bus.p0_cut;
            r_win   <= w_win;
        end
    end

    // 17-bit upper check so ad+3 cannot wrap; byte writes touch one byte only.
    assign w_lo    = r_ad < DM_BASE;
    assign w_hi    = (r_wr != WR_B) &&
                     (({1'b0, r_ad} + 17'd3) > {1'b0, DM_TOP});
    assign w_fault = w_lo | w_hi;
    assign w_rd    = ((r_wr == RD) && !w_fault) ? bus.DM : '0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_fault  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == ACCESS) begin
            r_fault <= w_fault;
            if (r_win) begin
                r_rdata1 <= w_rd;
            end else begin
                r_rdata0 <= w_rd;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_any ? ACCESS : IDLE;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.Ad        = DM_BASE;
        bus.WrData    = '0;
        bus.MemWr     = RD;
        bus.DMcut_sel = '0;
        bus.p0_gnt    = 1'b0;
        bus.p1_gnt    = 1'b0;
        bus.p0_rvalid = 1'b0;
        bus.p1_rvalid = 1'b0;
        bus.p0_err    = 1'b0;
        bus.p1_err    = 1'b0;
        unique case (r_state)
            ACCESS: begin
                bus.Ad        = r_ad;
                bus.WrData    = r_wdata;
                bus.MemWr     = w_fault ? RD : r_wr;
                bus.DMcut_sel = r_cut;
                bus.p0_gnt    = ~r_win;
                bus.p1_gnt    = r_win;
            end
            RESP: begin
                bus.p0_rvalid = ~r_win;
                bus.p1_rvalid = r_win;
                bus.p0_err    = ~r_win & r_fault;
                bus.p1_err    = r_win & r_fault;
            end
            default: ;
        endcase
    end

    assign bus.p0_rdata = r_rdata0;
    assign bus.p1_rdata = r_rdata1;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a byte-wide memory model.
// Define DM_ARB_ROUND_ROBIN_EN to check the round-robin tie break.
module tb_dm_arbiter;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    logic busy;
    logic init  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem [0:255];
    logic [7:0] w_a;

`ifdef DM_ARB_ROUND_ROBIN_EN
    localparam logic [2:0] RR_EXP = 3'b010;
`else
    localparam logic [2:0] RR_EXP = 3'b000;
`endif

    dm_arbiter_if bus ();

    dm_arbiter u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 Clk = ~Clk;

    assign w_a = bus.Ad[7:0];

    always_comb begin
        case (bus.DMcut_sel)
            2'd1:    bus.DM = {24'h0, mem[w_a]};
            2'd2:    bus.DM = {16'h0, mem[w_a + 8'd1], mem[w_a]};
            default: bus.DM = {mem[w_a + 8'd3], mem[w_a + 8'd2],
                               mem[w_a + 8'd1], mem[w_a]};
        endcase
    end

    always @(posedge Clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else begin
            case (bus.MemWr)
                3'd1, 3'd3: begin
                    mem[w_a]        <= bus.WrData[7:0];
                    mem[w_a + 8'd1] <= bus.WrData[15:8];
                    mem[w_a + 8'd2] <= bus.WrData[23:16];
                    mem[w_a + 8'd3] <= bus.WrData[31:24];
                end
                3'd2: mem[w_a] <= bus.WrData[7:0];
                3'd4: begin
                    mem[w_a]        <= bus.WrData[7:0];
                    mem[w_a + 8'd1] <= bus.WrData[15:8];
                end
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input bit port,
                          input logic [2:0] wr, input logic [15:0] ad,
                          input logic [31:0] wd, input logic [1:0] cut,
                          input logic [2:0] exp_mw, input logic [31:0] exp_rd,
                          input logic exp_err);
        if (port) begin
            bus.p1_wr = wr; bus.p1_ad = ad; bus.p1_wdata = wd;
            bus.p1_cut = cut; bus.p1_req = 1'b1;
        end else begin
            bus.p0_wr = wr; bus.p0_ad = ad; bus.p0_wdata = wd;
            bus.p0_cut = cut; bus.p0_req = 1'b1;
        end
        tick();
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_gnt"}, 32'(port ? bus.p1_gnt : bus.p0_gnt), 32'd1);
        chk({tag, "_ogn"}, 32'(port ? bus.p0_gnt : bus.p1_gnt), 32'd0);
        chk({tag, "_mw"}, 32'(bus.MemWr), 32'(exp_mw));
        chk({tag, "_ad"}, 32'(bus.Ad), 32'(ad));
        chk({tag, "_wd"}, bus.WrData, wd);
        chk({tag, "_rv_early"}, 32'(port ? bus.p1_rvalid : bus.p0_rvalid), 32'd0);
        if (port) bus.p1_req = 1'b0;
        else      bus.p0_req = 1'b0;
        tick();
        chk({tag, "_rv"}, 32'(port ? bus.p1_rvalid : bus.p0_rvalid), 32'd1);
        chk({tag, "_rd"}, port ? bus.p1_rdata : bus.p0_rdata, exp_rd);
        chk({tag, "_err"}, 32'(port ? bus.p1_err : bus.p0_err), 32'(exp_err));
        chk({tag, "_mw_resp"}, 32'(bus.MemWr), 32'd0);
        chk({tag, "_gnt_resp"}, 32'(port ? bus.p1_gnt : bus.p0_gnt), 32'd0);
        tick();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_rv_end"}, 32'(port ? bus.p1_rvalid : bus.p0_rvalid), 32'd0);
    endtask

    initial begin
        logic w;
        logic [2:0] rr;
        rr = RR_EXP;
        bus.p0_req = 0; bus.p0_wr = 0; bus.p0_ad = 0; bus.p0_wdata = 0; bus.p0_cut = 0;
        bus.p1_req = 0; bus.p1_wr = 0; bus.p1_ad = 0; bus.p1_wdata = 0; bus.p1_cut = 0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt0", 32'(bus.p0_gnt), 32'd0);
        chk("rst_gnt1", 32'(bus.p1_gnt), 32'd0);
        chk("rst_rv0", 32'(bus.p0_rvalid), 32'd0);
        chk("rst_rv1", 32'(bus.p1_rvalid), 32'd0);
        chk("rst_mw", 32'(bus.MemWr), 32'd0);
        chk("rst_ad", 32'(bus.Ad), 32'h0000ff00);
        chk("rst_wd", bus.WrData, 32'h0);
        chk("rst_rd0", bus.p0_rdata, 32'h0);
        tick();
        tick();
        init = 1'b0;
        tick();
        Reset = 1'b1;
        tick();

        access("wrw", 1'b0, 3'd1, 16'hff10, 32'hdeadbeef, 2'd0, 3'd1, 32'h0, 1'b0);
        access("rdw", 1'b0, 3'd0, 16'hff10, 32'h0, 2'd0, 3'd0, 32'hdeadbeef, 1'b0);
        access("wrb", 1'b0, 3'd2, 16'hff40, 32'h1234565a, 2'd0, 3'd2, 32'h0, 1'b0);
        access("rdb", 1'b0, 3'd0, 16'hff40, 32'h0, 2'd1, 3'd0, 32'h0000005a, 1'b0);
        access("rdh", 1'b0, 3'd0, 16'hff40, 32'h0, 2'd2, 3'd0, 32'h0000415a, 1'b0);
        access("wr6", 1'b0, 3'd6, 16'hff20, 32'h0, 2'd0, 3'd0, 32'h23222120, 1'b0);
        access("fhi", 1'b1, 3'd0, 16'hfffe, 32'h0, 2'd0, 3'd0, 32'h0, 1'b1);
        access("top", 1'b1, 3'd0, 16'hfffc, 32'h0, 2'd0, 3'd0, 32'hfffefdfc, 1'b0);
        access("flo", 1'b0, 3'd0, 16'hfeff, 32'h0, 2'd0, 3'd0, 32'h0, 1'b1);
        access("bff", 1'b0, 3'd2, 16'hffff, 32'h000000a7, 2'd0, 3'd2, 32'h0, 1'b0);
        access("fwr", 1'b0, 3'd1, 16'hfffd, 32'h55555555, 2'd0, 3'd0, 32'h0, 1'b1);

        bus.p1_wr = 3'd1; bus.p1_ad = 16'hff30;
        bus.p1_wdata = 32'h11223344; bus.p1_cut = 2'd0; bus.p1_req = 1'b1;
        tick();
        chk("rac_gnt1", 32'(bus.p1_gnt), 32'd1);
        chk("rac_mw", 32'(bus.MemWr), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        chk("rac_busy", 32'(busy), 32'd0);
        chk("rac_gnt1_rst", 32'(bus.p1_gnt), 32'd0);
        chk("rac_mw_rst", 32'(bus.MemWr), 32'd0);
        chk("rac_ad_rst", 32'(bus.Ad), 32'h0000ff00);
        chk("rac_wd_rst", bus.WrData, 32'h0);
        chk("rac_rd1_rst", bus.p1_rdata, 32'h0);
        chk("rac_rd0_rst", bus.p0_rdata, 32'h0);
        bus.p1_req = 1'b0;
        tick();
        chk("rac_rv1", 32'(bus.p1_rvalid), 32'd0);
        Reset = 1'b1;
        tick();
        chk("rac_rv1_post", 32'(bus.p1_rvalid), 32'd0);
        chk("rac_busy_post", 32'(busy), 32'd0);

        bus.p0_wr = 3'd0; bus.p0_ad = 16'hff00; bus.p0_cut = 2'd0;
        bus.p1_wr = 3'd0; bus.p1_ad = 16'hff04; bus.p1_cut = 2'd0;
        for (int r = 0; r < 3; r++) begin
            w = rr[r];
            bus.p0_req = 1'b1;
            bus.p1_req = 1'b1;
            tick();
            chk("tie_gnt0", 32'(bus.p0_gnt), 32'(!w));
            chk("tie_gnt1", 32'(bus.p1_gnt), 32'(w));
            if (w) bus.p1_req = 1'b0;
            else   bus.p0_req = 1'b0;
            tick();
            chk("tie_rv0", 32'(bus.p0_rvalid), 32'(!w));
            chk("tie_rv1", 32'(bus.p1_rvalid), 32'(w));
            chk("tie_rd", w ? bus.p1_rdata : bus.p0_rdata,
                w ? 32'h07060504 : 32'h03020100);
            tick();
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        tick();
        chk("tie_idle", 32'(busy), 32'd0);

        access("nowr", 1'b0, 3'd0, 16'hff30, 32'h0, 2'd0, 3'd0, 32'h33323130, 1'b0);
        access("rdff", 1'b0, 3'd0, 16'hfffc, 32'h0, 2'd1, 3'd0, 32'h000000fc, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
